irq_priority_sequencer: RTL

- Resolves priority among eight masked interrupt requests and drives the CPU interrupt line.
- Runs the two-pulse INTA acknowledge sequence and maintains the in-service register (ISR).
- Applies EOI and rotation commands.
- Sits between the IRR/IMR registers and the data-bus vector output in the PIC core. The IR-level one-hot decode is internal to this block.

---
 rtl/irq_priority_sequencer_if.sv | 27 ++
 rtl/irq_priority_sequencer.sv | 88 ++++++++
 2 files changed

// File: rtl/irq_priority_sequencer_if.sv
// irq_priority_sequencer_if: request, command and acknowledge signals between the PIC core and the priority sequencer
interface irq_priority_sequencer_if;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] icw2_base;
  logic       aeoi_mode;
  logic       rotate_on_aeoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       inta;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic       vector_valid;
  logic [7:0] vector;
  logic       spurious;
  modport master (
    output irr, imr, icw2_base, aeoi_mode, rotate_on_aeoi, eoi_valid, eoi_specific, eoi_rotate, eoi_level, inta,
    input  int_out, isr, irr_clear, vector_valid, vector, spurious
  );
  modport slave (
    input  irr, imr, icw2_base, aeoi_mode, rotate_on_aeoi, eoi_valid, eoi_specific, eoi_rotate, eoi_level, inta,
    output int_out, isr, irr_clear, vector_valid, vector, spurious
  );
endinterface

// File: rtl/irq_priority_sequencer.sv
// irq_priority_sequencer: rotating-priority resolver, two-pulse INTA sequencer and ISR/EOI handling.
// Optional SPECIAL_MASK_MODE_EN adds the smm input (special mask mode, ignores nesting).
module irq_priority_sequencer #(
  parameter logic [2:0] RESET_LOWEST_PRIO = 3'd7
) (
  input logic clk,
  input logic reset,
`ifdef SPECIAL_MASK_MODE_EN
  input logic smm,
`endif
  irq_priority_sequencer_if.slave bus
);
  typedef enum logic {IDLE, ACK1} state_t;
  state_t     state_q;
  logic [7:0] isr_q, isr_d, irr_clear_q, vector_q, pending, cand, set_mask, clr_mask;
  logic [2:0] lowest_q, lowest_d, level_q, winner, isr_top, eoi_lvl;
  logic       int_out_q, vector_valid_q, spurious_q, spur_q;
  logic       smm_on, int_cond, ack0, ack1, aeoi, eoi_hit;
  // Priority starts just above lp and wraps; scanning downward lets the highest-priority hit land last
  function automatic logic [2:0] top_level(input logic [7:0] v, input logic [2:0] lp);
    logic [2:0] l;
    top_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      l = lp + 3'd1 + 3'(i);
      if (v[l]) top_level = l;
    end
  endfunction
  function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] lp);
    return l - lp - 3'd1;
  endfunction
`ifdef SPECIAL_MASK_MODE_EN
  assign smm_on = smm;
`else
  assign smm_on = 1'b0;
`endif
  always_comb begin
    pending  = bus.irr & ~bus.imr;
    cand     = smm_on ? pending & ~isr_q : pending;
    winner   = top_level(cand, lowest_q);
    isr_top  = top_level(isr_q, lowest_q);
    int_cond = smm_on ? |cand : |pending && (~|isr_q || rank(winner, lowest_q) < rank(isr_top, lowest_q));
    ack0     = state_q == IDLE && bus.inta;
    ack1     = state_q == ACK1 && bus.inta;
    aeoi     = ack1 && bus.aeoi_mode && !spur_q;
    eoi_lvl  = bus.eoi_specific ? bus.eoi_level : isr_top;
    eoi_hit  = bus.eoi_valid && (bus.eoi_specific || |isr_q);
    set_mask = ack0 && |cand ? 8'd1 << winner : 8'd0;
    clr_mask = (eoi_hit ? 8'd1 << eoi_lvl : 8'd0) | (aeoi ? 8'd1 << level_q : 8'd0);
    isr_d    = (isr_q & ~clr_mask) | set_mask;
    lowest_d = aeoi && bus.rotate_on_aeoi ? level_q : eoi_hit && bus.eoi_rotate ? eoi_lvl : lowest_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      isr_q          <= 8'd0;
      lowest_q       <= RESET_LOWEST_PRIO;
      level_q        <= 3'd0;
      spur_q         <= 1'b0;
      int_out_q      <= 1'b0;
      irr_clear_q    <= 8'd0;
      vector_valid_q <= 1'b0;
      vector_q       <= 8'd0;
      spurious_q     <= 1'b0;
    end else begin
      isr_q          <= isr_d;
      lowest_q       <= lowest_d;
      int_out_q      <= state_q == IDLE && !bus.inta && int_cond;
      irr_clear_q    <= set_mask;
      spurious_q     <= ack0 && ~|cand;
      vector_valid_q <= ack1;
      if (ack0) begin
        level_q <= |cand ? winner : 3'd7;
        spur_q  <= ~|cand;
        state_q <= ACK1;
      end
      if (ack1) begin
        vector_q <= {bus.icw2_base, level_q};
        state_q  <= IDLE;
      end
    end
  end
  assign bus.int_out      = int_out_q;
  assign bus.isr          = isr_q;
  assign bus.irr_clear    = irr_clear_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.vector       = vector_q;
  assign bus.spurious     = spurious_q;
endmodule
